// File: rtl/register_file_write_bank_pkg.sv
`default_nettype none
// ============================================================================
// register_file_write_bank_pkg
// Shared index, width and reset constants for the register-file write bank.
// Revision: 1.0
// ============================================================================
package register_file_write_bank_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;
   localparam int COUNT_W    = 8;

   localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

   localparam int REG_ZERO = 0;
   localparam int REG_AT   = 1;
   localparam int REG_GP   = 28;
   localparam int REG_SP   = 29;
   localparam int REG_FP   = 30;
   localparam int REG_RA   = 31;

   localparam logic [31:0] SP_RESET_DEFAULT = 32'h7FFF_EFFC;
   localparam logic [31:0] GP_RESET_DEFAULT = 32'h1000_8000;

   typedef logic [REG_ADDR_W-1:0] reg_idx_t;

endpackage
`default_nettype wire

// File: rtl/register_file_write_bank_if.sv
`default_nettype none
// ============================================================================
// register_file_write_bank_if
// Write-back bundle: request, destination index and data.
// Revision: 1.0
// ============================================================================
interface register_file_write_bank_if #(
   parameter int N = 32
);
   import register_file_write_bank_pkg::*;

   logic         reg_write_i;
   reg_idx_t     write_register_i;
   logic [N-1:0] write_data_i;

   modport master (output reg_write_i, output write_register_i, output write_data_i);
   modport slave  (input  reg_write_i, input  write_register_i, input  write_data_i);

endinterface
`default_nettype wire

// File: rtl/register_file_write_bank_write_enable_decoder.sv
`default_nettype none
// ============================================================================
// register_file_write_bank_write_enable_decoder
// 5-to-32 one-hot write-enable decoder, gated by the write request.
// Revision: 1.0
// ============================================================================
module register_file_write_bank_write_enable_decoder
   import register_file_write_bank_pkg::*;
(
   input  wire logic                enable_i,
   input  wire reg_idx_t            index_i,
   output      logic [NUM_REGS-1:0] onehot_o
);

   // The index is only looked at when enabled, so an X index is harmless when idle.
   always_comb begin
      onehot_o = '0;
      if (enable_i) begin
         onehot_o[index_i] = 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/register_file_write_bank.sv
`default_nettype none
// ============================================================================
// register_file_write_bank
// 32 x N architectural registers with one-hot write, all values exposed in parallel.
// Optional macro REGFILE_WRITE_THROUGH_EN: same-cycle forwarding of write data.
// Revision: 1.0
// ============================================================================
module register_file_write_bank
   import register_file_write_bank_pkg::*;
#(
   parameter int           N        = 32,
   parameter logic [N-1:0] SP_RESET = SP_RESET_DEFAULT,
   parameter logic [N-1:0] GP_RESET = GP_RESET_DEFAULT
)(
   input  wire logic                     clk,
   input  wire logic                     reset,
   register_file_write_bank_if.slave     wb,
   output      logic [N-1:0]             register_0_o,
   output      logic [N-1:0]             register_1_o,
   output      logic [N-1:0]             register_2_o,
   output      logic [N-1:0]             register_3_o,
   output      logic [N-1:0]             register_4_o,
   output      logic [N-1:0]             register_5_o,
   output      logic [N-1:0]             register_6_o,
   output      logic [N-1:0]             register_7_o,
   output      logic [N-1:0]             register_8_o,
   output      logic [N-1:0]             register_9_o,
   output      logic [N-1:0]             register_10_o,
   output      logic [N-1:0]             register_11_o,
   output      logic [N-1:0]             register_12_o,
   output      logic [N-1:0]             register_13_o,
   output      logic [N-1:0]             register_14_o,
   output      logic [N-1:0]             register_15_o,
   output      logic [N-1:0]             register_16_o,
   output      logic [N-1:0]             register_17_o,
   output      logic [N-1:0]             register_18_o,
   output      logic [N-1:0]             register_19_o,
   output      logic [N-1:0]             register_20_o,
   output      logic [N-1:0]             register_21_o,
   output      logic [N-1:0]             register_22_o,
   output      logic [N-1:0]             register_23_o,
   output      logic [N-1:0]             register_24_o,
   output      logic [N-1:0]             register_25_o,
   output      logic [N-1:0]             register_26_o,
   output      logic [N-1:0]             register_27_o,
   output      logic [N-1:0]             register_28_o,
   output      logic [N-1:0]             register_29_o,
   output      logic [N-1:0]             register_30_o,
   output      logic [N-1:0]             register_31_o,
   output      logic [COUNT_W-1:0]       write_count_o
);

   logic [NUM_REGS-1:0] write_enable;
   logic [N-1:0]        regs_q [NUM_REGS];
   logic [N-1:0]        regs_d [NUM_REGS];
   logic [N-1:0]        reg_view [NUM_REGS];
   logic [COUNT_W-1:0]  write_count_q;
   logic [COUNT_W-1:0]  write_count_d;

   function automatic logic [N-1:0] reset_value(input int k);
      if (k == REG_GP) return GP_RESET;
      if (k == REG_SP) return SP_RESET;
      return '0;
   endfunction

   // Reset also masks the request so nothing can be forwarded while held in reset.
   register_file_write_bank_write_enable_decoder u_write_enable_decoder (
      .enable_i (wb.reg_write_i & ~reset),
      .index_i  (wb.write_register_i),
      .onehot_o (write_enable)
   );

   always_comb begin
      write_count_d = write_count_q;
      for (int k = 0; k < NUM_REGS; k++) begin
         regs_d[k] = write_enable[k] ? wb.write_data_i : regs_q[k];
      end
      regs_d[REG_ZERO] = '0;
      if ((|write_enable[NUM_REGS-1:1]) && (write_count_q != COUNT_MAX)) begin
         write_count_d = write_count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < NUM_REGS; k++) begin
            regs_q[k] <= reset_value(k);
         end
         write_count_q <= '0;
      end else begin
         regs_q        <= regs_d;
         write_count_q <= write_count_d;
      end
   end

   always_comb begin
      for (int k = 0; k < NUM_REGS; k++) begin
         reg_view[k] = regs_q[k];
`ifdef REGFILE_WRITE_THROUGH_EN
         if ((k != REG_ZERO) && write_enable[k]) begin
            reg_view[k] = wb.write_data_i;
         end
`endif
      end
   end

   assign write_count_o = write_count_q;

   assign register_0_o  = reg_view[0];
   assign register_1_o  = reg_view[1];
   assign register_2_o  = reg_view[2];
   assign register_3_o  = reg_view[3];
   assign register_4_o  = reg_view[4];
   assign register_5_o  = reg_view[5];
   assign register_6_o  = reg_view[6];
   assign register_7_o  = reg_view[7];
   assign register_8_o  = reg_view[8];
   assign register_9_o  = reg_view[9];
   assign register_10_o = reg_view[10];
   assign register_11_o = reg_view[11];
   assign register_12_o = reg_view[12];
   assign register_13_o = reg_view[13];
   assign register_14_o = reg_view[14];
   assign register_15_o = reg_view[15];
   assign register_16_o = reg_view[16];
   assign register_17_o = reg_view[17];
   assign register_18_o = reg_view[18];
   assign register_19_o = reg_view[19];
   assign register_20_o = reg_view[20];
   assign register_21_o = reg_view[21];
   assign register_22_o = reg_view[22];
   assign register_23_o = reg_view[23];
   assign register_24_o = reg_view[24];
   assign register_25_o = reg_view[25];
   assign register_26_o = reg_view[26];
   assign register_27_o = reg_view[27];
   assign register_28_o = reg_view[28];
   assign register_29_o = reg_view[29];
   assign register_30_o = reg_view[30];
   assign register_31_o = reg_view[31];

endmodule
`default_nettype wire

// File: tb/tb_register_file_write_bank.sv
`default_nettype none
// ============================================================================
// tb_register_file_write_bank
// Scoreboard bench for the register-file write bank.
// Revision: 1.0
// ============================================================================
module tb_register_file_write_bank;
   import register_file_write_bank_pkg::*;

   typedef struct {
      logic [4:0]  idx;
      logic [31:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] regs [32];
   logic [7:0]  write_count;

   logic [31:0] model [32];
   logic [7:0]  exp_count;
   exp_t        sb [$];
   int          checks = 0;
   int          errors = 0;

   register_file_write_bank_if #(.N(32)) wb ();

   register_file_write_bank #(.N(32)) dut (
      .clk(clk), .reset(reset), .wb(wb.slave),
      .register_0_o(regs[0]),   .register_1_o(regs[1]),   .register_2_o(regs[2]),   .register_3_o(regs[3]),
      .register_4_o(regs[4]),   .register_5_o(regs[5]),   .register_6_o(regs[6]),   .register_7_o(regs[7]),
      .register_8_o(regs[8]),   .register_9_o(regs[9]),   .register_10_o(regs[10]), .register_11_o(regs[11]),
      .register_12_o(regs[12]), .register_13_o(regs[13]), .register_14_o(regs[14]), .register_15_o(regs[15]),
      .register_16_o(regs[16]), .register_17_o(regs[17]), .register_18_o(regs[18]), .register_19_o(regs[19]),
      .register_20_o(regs[20]), .register_21_o(regs[21]), .register_22_o(regs[22]), .register_23_o(regs[23]),
      .register_24_o(regs[24]), .register_25_o(regs[25]), .register_26_o(regs[26]), .register_27_o(regs[27]),
      .register_28_o(regs[28]), .register_29_o(regs[29]), .register_30_o(regs[30]), .register_31_o(regs[31]),
      .write_count_o(write_count)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic model_reset();
      for (int k = 0; k < 32; k++) model[k] = 32'h0;
      model[28] = 32'h1000_8000;
      model[29] = 32'h7FFF_EFFC;
      exp_count = 8'd0;
      sb.delete();
   endtask

   // Drives one write request for one cycle; expected results enter the scoreboard here.
   task automatic drive_write(input logic we, input logic [4:0] idx, input logic [31:0] data);
      @(negedge clk);
      wb.reg_write_i      = we;
      wb.write_register_i = idx;
      wb.write_data_i     = data;
      if (we === 1'b1 && idx !== 5'd0) begin
         model[idx] = data;
         sb.push_back('{idx: idx, data: data});
         if (exp_count != 8'd255) exp_count = exp_count + 8'd1;
      end
      @(posedge clk);
      #1;
      wb.reg_write_i = 1'b0;
   endtask

   task automatic test_reset();
      wb.reg_write_i = 1'b0; wb.write_register_i = 5'd0; wb.write_data_i = 32'h0;
      @(posedge clk);
      #7;
      reset = 1'b1;
      model_reset();
      #1;
      for (int k = 0; k < 32; k++) begin
         checks++;
         if (regs[k] !== model[k]) begin
            errors++;
            $display("FAIL reset_reg%0d: got %h expected %h", k, regs[k], model[k]);
         end
      end
      checks++;
      if (write_count !== 8'd0) begin
         errors++;
         $display("FAIL reset_count: got %0d expected 0", write_count);
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_basic_write();
      drive_write(1'b1, 5'd8, 32'hDEAD_BEEF);
      while (sb.size() > 0) begin
         exp_t e = sb.pop_front();
         checks++;
         if (regs[e.idx] !== e.data) begin
            errors++;
            $display("FAIL basic_write reg%0d: got %h expected %h", e.idx, regs[e.idx], e.data);
         end
      end
      for (int k = 0; k < 32; k++) begin
         checks++;
         if (regs[k] !== model[k]) begin
            errors++;
            $display("FAIL basic_others reg%0d: got %h expected %h", k, regs[k], model[k]);
         end
      end
      checks++;
      if (write_count !== 8'd1) begin
         errors++;
         $display("FAIL basic_count: got %0d expected 1", write_count);
      end
   endtask

   task automatic test_zero_protect();
      drive_write(1'b1, 5'd0, 32'hFFFF_FFFF);
      checks++;
      if (regs[0] !== 32'h0) begin
         errors++;
         $display("FAIL zero_reg0: got %h expected 00000000", regs[0]);
      end
      checks++;
      if (write_count !== exp_count) begin
         errors++;
         $display("FAIL zero_count: got %0d expected %0d", write_count, exp_count);
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL zero_scoreboard: got %0d entries expected 0", sb.size());
      end
   endtask

   task automatic test_enable_gating();
      drive_write(1'b0, 5'd5, 32'h0000_1234);
      drive_write(1'b0, 5'bx, 32'hxxxx_xxxx);
      for (int k = 0; k < 32; k++) begin
         checks++;
         if (regs[k] !== model[k]) begin
            errors++;
            $display("FAIL gating reg%0d: got %h expected %h", k, regs[k], model[k]);
         end
      end
      checks++;
      if (write_count !== exp_count) begin
         errors++;
         $display("FAIL gating_count: got %0d expected %0d", write_count, exp_count);
      end
   endtask

   task automatic test_back_to_back();
      for (int v = 1; v <= 3; v++) begin
         drive_write(1'b1, 5'd31, 32'(v));
         while (sb.size() > 0) begin
            exp_t e = sb.pop_front();
            checks++;
            if (regs[e.idx] !== e.data) begin
               errors++;
               $display("FAIL b2b step%0d reg%0d: got %h expected %h", v, e.idx, regs[e.idx], e.data);
            end
         end
      end
      checks++;
      if (write_count !== exp_count) begin
         errors++;
         $display("FAIL b2b_count: got %0d expected %0d", write_count, exp_count);
      end
   endtask

   task automatic test_write_through();
      logic [31:0] same_cycle_exp;
      @(negedge clk);
`ifdef REGFILE_WRITE_THROUGH_EN
      same_cycle_exp = 32'hA5A5_A5A5;
`else
      same_cycle_exp = model[3];
`endif
      wb.reg_write_i = 1'b1; wb.write_register_i = 5'd3; wb.write_data_i = 32'hA5A5_A5A5;
      model[3] = 32'hA5A5_A5A5;
      sb.push_back('{idx: 5'd3, data: 32'hA5A5_A5A5});
      if (exp_count != 8'd255) exp_count = exp_count + 8'd1;
      #1;
      checks++;
      if (regs[3] !== same_cycle_exp) begin
         errors++;
         $display("FAIL wt_same_cycle: got %h expected %h", regs[3], same_cycle_exp);
      end
      checks++;
      if (regs[0] !== 32'h0) begin
         errors++;
         $display("FAIL wt_reg0: got %h expected 00000000", regs[0]);
      end
      @(posedge clk);
      #1;
      wb.reg_write_i = 1'b0;
      while (sb.size() > 0) begin
         exp_t e = sb.pop_front();
         checks++;
         if (regs[e.idx] !== e.data) begin
            errors++;
            $display("FAIL wt_next_cycle reg%0d: got %h expected %h", e.idx, regs[e.idx], e.data);
         end
      end
      checks++;
      if (write_count !== exp_count) begin
         errors++;
         $display("FAIL wt_count: got %0d expected %0d", write_count, exp_count);
      end
   endtask

   task automatic test_reset_mid_write();
      @(negedge clk);
      wb.reg_write_i = 1'b1; wb.write_register_i = 5'd9; wb.write_data_i = 32'h0000_0099;
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      checks++;
      if (regs[9] !== 32'h0 || regs[31] !== 32'h0 || regs[28] !== 32'h1000_8000) begin
         errors++;
         $display("FAIL midreset_async: got r9=%h r31=%h r28=%h expected 0/0/10008000", regs[9], regs[31], regs[28]);
      end
      checks++;
      if (write_count !== 8'd0) begin
         errors++;
         $display("FAIL midreset_count: got %0d expected 0", write_count);
      end
      @(posedge clk);
      #1;
      checks++;
      if (regs[9] !== 32'h0) begin
         errors++;
         $display("FAIL midreset_held: got %h expected 00000000", regs[9]);
      end
      @(negedge clk);
      reset = 1'b0;
      wb.write_data_i = 32'h1234_5678;
      model[9] = 32'h1234_5678;
      sb.push_back('{idx: 5'd9, data: 32'h1234_5678});
      exp_count = 8'd1;
      @(posedge clk);
      #1;
      wb.reg_write_i = 1'b0;
      while (sb.size() > 0) begin
         exp_t e = sb.pop_front();
         checks++;
         if (regs[e.idx] !== e.data) begin
            errors++;
            $display("FAIL midreset_release reg%0d: got %h expected %h", e.idx, regs[e.idx], e.data);
         end
      end
      checks++;
      if (write_count !== exp_count) begin
         errors++;
         $display("FAIL midreset_release_count: got %0d expected %0d", write_count, exp_count);
      end
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 300; i++) begin
         drive_write(1'b1, 5'd1, 32'(i + 100));
         while (sb.size() > 0) begin
            exp_t e = sb.pop_front();
            checks++;
            if (regs[e.idx] !== e.data) begin
               errors++;
               $display("FAIL sat_data i=%0d: got %h expected %h", i, regs[e.idx], e.data);
            end
         end
         checks++;
         if (write_count !== exp_count) begin
            errors++;
            $display("FAIL sat_count i=%0d: got %0d expected %0d", i, write_count, exp_count);
         end
      end
      checks++;
      if (write_count !== 8'd255) begin
         errors++;
         $display("FAIL sat_final: got %0d expected 255", write_count);
      end
   endtask

   initial begin
      test_reset();
      test_basic_write();
      test_zero_protect();
      test_enable_gating();
      test_back_to_back();
      test_write_through();
      test_reset_mid_write();
      test_saturation();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/register_file_write_bank.md
Name: register_file_write_bank

Overview:
- Write side of the processor register file: decodes the 5-bit destination index into one-hot write enables and holds the 32 architectural registers.
- Presents all 32 register values in parallel to the read-port multiplexers (one mux per read port, rs and rt).
- Sits between the write-back stage (reg_write/dest/data) and the read muxes of the decode stage.

Parameters:
N, 32, data width of each register
SP_RESET, 32'h7FFF_EFFC, reset value of register 29 ($sp)
GP_RESET, 32'h1000_8000, reset value of register 28 ($gp)

Ports:
clk  input  1  single clock, all state updates on rising edge
reset  input  1  asynchronous, active-high; clears/initialises all registers immediately
reg_write_i  input  1  write request from write-back stage
write_register_i  input  5  destination register index 0..31
write_data_i  input  N  data to write
register_k_o  output  N  current value of register k, one port per k = 0..31 (register_0_o ... register_31_o)
write_count_o  output  8  saturating count of committed writes since reset (debug/perf)

Behaviour:
- Reset (async, active-high): register_28 = GP_RESET, register_29 = SP_RESET, all others 0, write_count_o = 0; takes effect without a clock edge; held while reset high; writes during reset ignored.
- Decoder: combinational 5-to-32 one-hot, gated by reg_write_i; at most one enable active per cycle.
- Commit: on rising clk with reg_write_i=1 and write_register_i=k, k!=0: register_k <= write_data_i; visible on register_k_o the cycle after (latency 1).
- Register 0: hardwired to 0; register_0_o always 0; a write to index 0 is discarded and does not increment write_count_o.
- reg_write_i=0: no register changes regardless of index/data (X on index/data tolerated).
- write_count_o: +1 per committed write (k!=0); saturates at 255, never wraps.
- Reset asserted mid-operation: any write in the same cycle is lost; all state returns to reset values asynchronously; the first write is accepted on the first rising edge after reset deasserts.
- Back-to-back writes to the same register: the last write wins, one per cycle; no hazards inside the block.
- No read addressing inside this block; selection is done by the external read muxes.

Optional Feature:
REGFILE_WRITE_THROUGH_EN
- Defined: when reg_write_i=1 and write_register_i=k (k!=0), register_k_o combinationally shows write_data_i in the same cycle (write-first forwarding). This removes the write-back/decode same-cycle hazard. register_0_o stays 0. Stored state and write_count_o are unchanged.
- Undefined: outputs are pure flop values; new data appears one cycle after the write.

Decomposition:
- Shared package:
  - register index constants REG_ZERO=0, REG_AT=1, REG_GP=28, REG_SP=29, REG_FP=30, REG_RA=31
  - SP_RESET/GP_RESET defaults
  - width constants (REG_ADDR_W=5, NUM_REGS=32)
- Sub-module: write_enable_decoder (5-bit index + enable -> 32-bit one-hot), instantiated once.
- Register storage is an array of flops in the top module.

Test Plan:
- Reset check: assert reset asynchronously between clock edges -> register_28_o=32'h1000_8000, register_29_o=32'h7FFF_EFFC, all other outputs 0, write_count_o=0 without waiting for a clock edge.
- Basic write: reg_write_i=1, index 8, data 32'hDEAD_BEEF for one cycle -> register_8_o=32'hDEAD_BEEF next cycle, all other registers unchanged, write_count_o=1.
- Zero protect: write 32'hFFFF_FFFF to index 0 -> register_0_o stays 0, write_count_o unchanged.
- Enable gating: reg_write_i=0, index 5, data 32'h1234 -> register_5_o unchanged. Then writes 1,2,3 on consecutive cycles to index 31 -> register_31_o steps 1,2,3 one cycle behind.
- Reset mid-write: a write to index 9 is pending and reset asserts before the edge -> register_9_o=0, and a write 1 cycle after release commits. Separately, 300 writes -> write_count_o=255.
- With REGFILE_WRITE_THROUGH_EN: write 32'hA5A5_A5A5 to index 3 -> register_3_o=32'hA5A5_A5A5 in the same cycle. Without the macro, the value appears in the next cycle.
